// File: rtl/mdu_div_core.sv
// Iterative radix-2 restoring divider for the E-stage MDU.
// One quotient bit per cycle, then a sign-fixup cycle that registers the results.
module mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic             Cancel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  // Operand magnitudes; the most negative value maps onto itself.
  assign a_neg_c = Signed & A[WIDTH-1];
  assign b_neg_c = Signed & B[WIDTH-1];
  assign abs_a_c = a_neg_c ? -A : A;
  assign abs_b_c = b_neg_c ? -B : B;

  // Restoring step: a clear borrow bit means the trial subtraction fits.
  assign trial_c = {rem, quo[WIDTH-1]};
  assign diff_c  = trial_c - {1'b0, mag_b};

  // Truncating division: remainder follows the dividend's sign.
  assign quo_fix_c = b_zero ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
  assign rem_fix_c = sign_a ? -rem : rem;

  always_comb begin
    state_nxt = state;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (Start && !Cancel) state_nxt = CALC;
      CALC: begin
        if (Cancel)                        state_nxt = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX: begin
        done_nxt  = !Cancel;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Busy  <= busy_nxt;
      Done  <= done_nxt;
    end
  end

  // Datapath: operand capture, shift/subtract iterations and result registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
      mag_b     <= '0;
      rem       <= '0;
      quo       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Cancel) begin
            sign_a <= a_neg_c;
            sign_b <= b_neg_c;
            b_zero <= (B == '0);
            mag_b  <= abs_b_c;
            quo    <= abs_a_c;
            rem    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (!Cancel) begin
            if (!diff_c[WIDTH]) begin
              rem <= diff_c[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= trial_c[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (!Cancel) begin
            Quotient  <= quo_fix_c;
            Remainder <= rem_fix_c;
            DivZero   <= b_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mdu_div_core.md
Name: mdu_div_core

Overview:
- Iterative radix-2 restoring divider that feeds the E-stage multiply/divide unit.
- Replaces the single-cycle behavioural divide with a one-bit-per-cycle datapath.
- The MDU issues Start on DIV/DIVU, holds its own Busy while this core is busy, and copies Quotient/Remainder into its LO/HI staging registers on Done.
- Cancel lets the exception/flush logic kill an in-flight divide.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
Clk  input  1  clock; all state changes on rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request a divide; sampled only when idle.
Signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with Start.
Cancel  input  1  abort the in-flight divide (exception/flush).
A  input  WIDTH  dividend; sampled with Start.
B  input  WIDTH  divisor; sampled with Start.
Busy  output  1  high while a divide is in progress.
Done  output  1  one-cycle pulse; Quotient/Remainder valid from this cycle on.
Quotient  output  WIDTH  result quotient (to LO).
Remainder  output  WIDTH  result remainder (to HI).
DivZero  output  1  set with Done when B was 0; held until next Done.

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset: state=IDLE; Busy=0, Done=0, Quotient=0, Remainder=0, DivZero=0; internal counter/registers=0. Reset overrides Start/Cancel, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with Start=1: latch Signed, sign of A, sign of B, |A|, |B|.
    - Magnitudes use two's-complement negation when Signed and the MSB=1.
    - 0x80000000 keeps magnitude 0x80000000.
  - Clear the partial remainder; cnt=0; go to CALC.
- CALC:
  - One restoring step per edge: shift {rem, quo} left 1 and trial-subtract |B|. If non-negative, keep the difference and set the quotient LSB=1.
  - cnt increments each step. After WIDTH steps, go to FIX.
- FIX (one edge):
  - Quotient negated iff Signed and sign(A)!=sign(B).
  - Remainder negated iff Signed and sign(A)=1.
  - This gives truncation toward zero, with the remainder taking the dividend's sign.
  - Register the outputs, pulse Done for the following cycle, return to IDLE.
- Latency: Start sampled at edge E0 → Busy=1 after E0 through E(WIDTH+1). Done=1 and Busy=0 in the cycle after E(WIDTH+1), i.e. 34 cycles after Start for WIDTH=32.
- Busy is a registered output: 1 in CALC and FIX, 0 in IDLE.
- Done is high exactly one cycle per completed divide and is never asserted after Cancel or Reset.
- Start while Busy=1 is ignored (no restart, no queue).
- Start in the same cycle that Done is high is accepted: the core is already IDLE.
- Cancel:
  - In CALC/FIX: return to IDLE on that edge; Busy=0 next cycle; no Done.
  - Quotient/Remainder/DivZero keep their previous values.
  - Cancel and Start together while IDLE: Cancel wins and Start is dropped.
- Divide by zero (B=0, either mode): full latency still taken. Quotient=all ones, Remainder=A (original bits), DivZero=1 with Done.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Quotient=0x80000000, Remainder=0, DivZero=0 (wraps, no trap).
- Outputs change only on the FIX edge or Reset; they stay stable between divides.

Test Plan:
- Unsigned 100/7, Start one cycle → Busy high 33 cycles, Done at cycle 34, Quotient=14, Remainder=2, DivZero=0.
- Signed -7/2 (0xFFFFFFF9/0x2) → Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF. Signed 7/-2 → Quotient=0xFFFFFFFD, Remainder=1.
- 0x80000000/0xFFFFFFFF:
  - Signed → Quotient=0x80000000, Remainder=0.
  - Unsigned → Quotient=0, Remainder=0x80000000.
- 5/0 in both modes → Quotient=0xFFFFFFFF, Remainder=5, DivZero=1. A following 9/3 → Quotient=3, Remainder=0, DivZero=0.
- Second Start at cycle 5 of a busy divide → ignored, first result unchanged, exactly one Done pulse. Start on the Done cycle → new divide accepted, Done 34 cycles later.
- Cancel at cycle 10 → Busy=0 next cycle, no Done, outputs hold prior result. Reset at cycle 20 of another divide → all outputs 0 next cycle, no Done.
